// File: rtl/clause_array.sv
// Clause bin storage with combinational unit propagation, conflict detection
// and lowest-empty-slot reporting for learnt-clause insertion.
module clause_array #(
  parameter int NUM_CLAUSES = 8,
  parameter int NUM_VARS    = 8,
  parameter int WIDTH_LVL   = 16,
  parameter int WIDTH_C_LEN = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CLAUSES-1:0]        wr_i,
  input  logic [2*NUM_VARS-1:0]         clause_i,
  input  logic [WIDTH_C_LEN:0]          clause_len_i,
  input  logic [3*NUM_VARS-1:0]         var_value_i,
  input  logic [WIDTH_LVL*NUM_VARS-1:0] var_lvl_i,
  input  logic                          apply_impl_i,
  input  logic                          apply_bkt_i,
  output logic [3*NUM_VARS-1:0]         var_value_o,
  output logic [WIDTH_LVL*NUM_VARS-1:0] var_lvl_o,
  output logic [2*NUM_VARS-1:0]         clause_o,
  output logic [WIDTH_C_LEN:0]          clause_len_o,
  output logic [NUM_CLAUSES-1:0]        learntc_insert_index_o
);

  localparam int CW = $clog2(NUM_VARS + 1);

  logic [2*NUM_VARS-1:0] clause_mem [NUM_CLAUSES];
  logic [WIDTH_C_LEN:0]  len_mem    [NUM_CLAUSES];

  logic [NUM_CLAUSES-1:0] conflict;
  logic [NUM_CLAUSES-1:0] unit;
  logic [NUM_VARS-1:0]    unit_mask [NUM_CLAUSES];
  logic [1:0]             unit_code [NUM_CLAUSES];
  logic [WIDTH_LVL-1:0]   unit_lvl  [NUM_CLAUSES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_CLAUSES; k++) begin
        clause_mem[k] <= '0;
        len_mem[k]    <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_CLAUSES; k++) begin
        if (wr_i[k]) begin
          clause_mem[k] <= clause_i;
          len_mem[k]    <= clause_len_i;
        end
      end
    end
  end

  // Per-clause literal classification; codes 00 and 11 are both absent.
  always_comb begin : eval_p
    logic [CW-1:0]        n_lit;
    logic [CW-1:0]        n_false;
    logic [CW-1:0]        n_free;
    logic                 any_true;
    logic                 occupied;
    logic [1:0]           code;
    logic [1:0]           val;
    logic [WIDTH_LVL-1:0] lvl;
    logic [WIDTH_LVL-1:0] max_lvl;
    logic [NUM_VARS-1:0]  free_mask;
    logic [1:0]           free_code;
    conflict = '0;
    unit     = '0;
    for (int c = 0; c < NUM_CLAUSES; c++) begin
      unit_mask[c] = '0;
      unit_code[c] = '0;
      unit_lvl[c]  = '0;
      n_lit        = '0;
      n_false      = '0;
      n_free       = '0;
      any_true     = 1'b0;
      max_lvl      = '0;
      free_mask    = '0;
      free_code    = '0;
      for (int v = 0; v < NUM_VARS; v++) begin
        code = clause_mem[c][2*v +: 2];
        val  = var_value_i[3*v+1 +: 2];
        lvl  = var_lvl_i[WIDTH_LVL*v +: WIDTH_LVL];
        if (code == 2'b01 || code == 2'b10) begin
          n_lit = n_lit + CW'(1);
          if (val == code) begin
            any_true = 1'b1;
          end else if (val == ~code) begin
            n_false = n_false + CW'(1);
            if (lvl > max_lvl) max_lvl = lvl;
          end else if (val == 2'b00) begin
            n_free       = n_free + CW'(1);
            free_mask[v] = 1'b1;
            free_code    = code;
          end
        end
      end
      occupied    = (len_mem[c] != '0);
      conflict[c] = occupied && (n_lit != '0) && (n_false == n_lit);
      unit[c]     = occupied && !any_true && (n_free == CW'(1)) &&
                    ((n_free + n_false) == n_lit);
      if (unit[c]) begin
        unit_mask[c] = free_mask;
        unit_code[c] = free_code;
        unit_lvl[c]  = max_lvl;
      end
    end
  end

  // Lowest clause index claims a var first when several clauses imply it.
  always_comb begin : resolve_p
    logic [NUM_VARS-1:0] claimed;
    var_value_o = var_value_i;
    var_lvl_o   = var_lvl_i;
    claimed     = '0;
    if (apply_impl_i && !apply_bkt_i) begin
      for (int c = 0; c < NUM_CLAUSES; c++) begin
        for (int v = 0; v < NUM_VARS; v++) begin
          if (unit_mask[c][v] && !claimed[v]) begin
            claimed[v]                           = 1'b1;
            var_value_o[3*v +: 3]                = {unit_code[c], 1'b1};
            var_lvl_o[WIDTH_LVL*v +: WIDTH_LVL] = unit_lvl[c];
          end
        end
      end
    end
  end

  always_comb begin : select_p
    logic found;
    clause_o               = '0;
    clause_len_o           = '0;
    learntc_insert_index_o = '0;
    for (int c = NUM_CLAUSES - 1; c >= 0; c--) begin
      if (conflict[c]) begin
        clause_o     = clause_mem[c];
        clause_len_o = len_mem[c];
      end
    end
    found = 1'b0;
    for (int c = 0; c < NUM_CLAUSES; c++) begin
      if (!found && len_mem[c] == '0) begin
        learntc_insert_index_o[c] = 1'b1;
        found                     = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_clause_array.sv
// Bench for clause_array: directed vector table, hand-written sequences and
// randomized traffic checked against a literal-counting reference model.
module tb_clause_array;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   wr_i;
  logic [15:0]  clause_i;
  logic [4:0]   clause_len_i;
  logic [23:0]  var_value_i;
  logic [127:0] var_lvl_i;
  logic         apply_impl_i;
  logic         apply_bkt_i;
  logic [23:0]  var_value_o;
  logic [127:0] var_lvl_o;
  logic [15:0]  clause_o;
  logic [4:0]   clause_len_o;
  logic [7:0]   learntc_insert_index_o;

  clause_array dut (
    .clk                    (clk),
    .rst                    (rst),
    .wr_i                   (wr_i),
    .clause_i               (clause_i),
    .clause_len_i           (clause_len_i),
    .var_value_i            (var_value_i),
    .var_lvl_i              (var_lvl_i),
    .apply_impl_i           (apply_impl_i),
    .apply_bkt_i            (apply_bkt_i),
    .var_value_o            (var_value_o),
    .var_lvl_o              (var_lvl_o),
    .clause_o               (clause_o),
    .clause_len_o           (clause_len_o),
    .learntc_insert_index_o (learntc_insert_index_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Reference model state: what each slot holds.
  logic [15:0] m_clause [8];
  logic [4:0]  m_len    [8];
  logic [23:0]  e_vv;
  logic [127:0] e_lvl;
  logic [15:0]  e_clause;
  logic [4:0]   e_len;
  logic [7:0]   e_ins;

  task automatic model_reset();
    for (int k = 0; k < 8; k++) begin
      m_clause[k] = '0;
      m_len[k]    = '0;
    end
  endtask

  task automatic model_write(input logic [7:0] m, input logic [15:0] cl, input logic [4:0] ln);
    for (int k = 0; k < 8; k++)
      if (m[k]) begin
        m_clause[k] = cl;
        m_len[k]    = ln;
      end
  endtask

  // Evaluate the clause database with integer literal counts.
  task automatic model_eval();
    int  val, code, nlit, ntrue, nfalse, nfree, fv, fc, mx;
    bit  claimed [8];
    bit  got_conf;
    e_vv = var_value_i;
    e_lvl = var_lvl_i;
    e_clause = 0;
    e_len = 0;
    e_ins = 0;
    got_conf = 0;
    for (int v = 0; v < 8; v++) claimed[v] = 0;
    for (int c = 0; c < 8; c++) begin
      if (m_len[c] == 0) continue;
      nlit = 0; ntrue = 0; nfalse = 0; nfree = 0; fv = 0; fc = 0; mx = 0;
      for (int v = 0; v < 8; v++) begin
        code = (m_clause[c] >> (2*v)) & 3;
        val  = (var_value_i >> (3*v+1)) & 3;
        if (code != 1 && code != 2) continue;
        nlit++;
        if (val == code) ntrue++;
        else if (val == 3 - code) begin
          nfalse++;
          if (((var_lvl_i >> (16*v)) & 16'hFFFF) > mx) mx = int'((var_lvl_i >> (16*v)) & 16'hFFFF);
        end else if (val == 0) begin
          nfree++; fv = v; fc = code;
        end
      end
      if (!got_conf && nlit > 0 && nfalse == nlit) begin
        got_conf = 1;
        e_clause = m_clause[c];
        e_len = m_len[c];
      end
      if (ntrue == 0 && nfree == 1 && nfalse == nlit - 1 && !claimed[fv]
          && apply_impl_i && !apply_bkt_i) begin
        claimed[fv] = 1;
        e_vv[3*fv +: 3] = {fc[1:0], 1'b1};
        e_lvl[16*fv +: 16] = mx[15:0];
      end
    end
    for (int c = 0; c < 8; c++)
      if (m_len[c] == 0) begin
        e_ins[c] = 1'b1;
        break;
      end
  endtask

  task automatic chk_model(input string tag);
    model_eval();
    chk({tag, "_vv"},  var_value_o, e_vv);
    chk({tag, "_lvl"}, var_lvl_o, e_lvl);
    chk({tag, "_cl"},  clause_o, e_clause);
    chk({tag, "_len"}, clause_len_o, e_len);
    chk({tag, "_ins"}, learntc_insert_index_o, e_ins);
  endtask

  task automatic write_slot(input logic [7:0] m, input logic [15:0] cl, input logic [4:0] ln);
    wr_i = m; clause_i = cl; clause_len_i = ln;
    @(posedge clk); #1;
    model_write(m, cl, ln);
    wr_i = '0;
  endtask

  typedef struct {
    logic [23:0]  vv;
    logic [127:0] lvl;
    logic         impl;
    logic         bkt;
    logic [23:0]  x_vv;
    logic [127:0] x_lvl;
    logic [15:0]  x_cl;
    logic [4:0]   x_len;
  } vec_t;

  vec_t tbl [6];
  localparam logic [127:0] L0 = 128'h0005_0007_0003;
  localparam logic [127:0] LP = (128'd12 << 96) | (128'd9 << 80);

  initial begin
    // Slot 0 = {var0 neg, var2 pos}; vectors against that single clause.
    tbl[0] = '{24'h000002, L0, 1'b1, 1'b0, 24'h0000C2, 128'h0003_0007_0003, 16'h0, 5'd0};
    tbl[1] = '{24'h000002, L0, 1'b1, 1'b1, 24'h000002, L0, 16'h0, 5'd0};
    tbl[2] = '{24'h000002, L0, 1'b0, 1'b0, 24'h000002, L0, 16'h0, 5'd0};
    tbl[3] = '{24'h000004, L0, 1'b1, 1'b0, 24'h000004, L0, 16'h0, 5'd0};
    tbl[4] = '{24'h000102, L0, 1'b1, 1'b0, 24'h000102, L0, 16'h0012, 5'd2};
    tbl[5] = '{24'h000082, L0, 1'b1, 1'b0, 24'h000082, L0, 16'h0, 5'd0};

    model_reset();
    rst = 1'b1; wr_i = '0; clause_i = '0; clause_len_i = '0;
    var_value_i = 24'h123456; var_lvl_i = {4{32'hDEADBEEF}};
    apply_impl_i = 1'b1; apply_bkt_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_ins", learntc_insert_index_o, 8'b0000_0001);
    chk("rst_cl", clause_o, 16'h0);
    chk("rst_len", clause_len_o, 5'd0);
    chk("rst_vv", var_value_o, 24'h123456);
    chk("rst_lvl", var_lvl_o, {4{32'hDEADBEEF}});

    write_slot(8'h01, 16'h0012, 5'd2);
    chk("one_ins", learntc_insert_index_o, 8'b0000_0010);
    for (int i = 0; i < 6; i++) begin
      var_value_i = tbl[i].vv; var_lvl_i = tbl[i].lvl;
      apply_impl_i = tbl[i].impl; apply_bkt_i = tbl[i].bkt;
      #1;
      chk($sformatf("tbl%0d_vv", i), var_value_o, tbl[i].x_vv);
      chk($sformatf("tbl%0d_lvl", i), var_lvl_o, tbl[i].x_lvl);
      chk($sformatf("tbl%0d_cl", i), clause_o, tbl[i].x_cl);
      chk($sformatf("tbl%0d_len", i), clause_len_o, tbl[i].x_len);
    end

    write_slot(8'h02, 16'h0900, 5'd2);
    write_slot(8'h04, 16'h1200, 5'd2);
    write_slot(8'h08, 16'h0005, 5'd2);
    write_slot(8'h10, 16'h4040, 5'd2);
    chk("five_ins", learntc_insert_index_o, 8'b0010_0000);

    apply_impl_i = 1'b1; apply_bkt_i = 1'b0; var_lvl_i = LP;
    var_value_i = 24'h000424; #1;
    chk("conf_cl", clause_o, 16'h0005);
    chk("conf_len", clause_len_o, 5'd2);
    chk_model("conf");
    var_value_i = 24'h000414; #1;
    chk("sat_cl", clause_o, 16'h0);

    var_value_i = 24'h110410; #1;
    chk("prio_vv", var_value_o, 24'h113410);
    chk("prio_lvl", var_lvl_o, LP | (128'd9 << 64));
    chk_model("prio");

    write_slot(8'hE0, 16'h8080, 5'd2);
    chk("full_ins", learntc_insert_index_o, 8'b0000_0000);
    chk_model("full");

    rst = 1'b1; wr_i = 8'hFF; clause_i = 16'h0900; clause_len_i = 5'd3;
    @(posedge clk); #1;
    rst = 1'b0; wr_i = '0; model_reset();
    chk("post_rst_ins", learntc_insert_index_o, 8'b0000_0001);
    chk("post_rst_vv", var_value_o, 24'h110410);
    chk("post_rst_lvl", var_lvl_o, LP);
    chk("post_rst_cl", clause_o, 16'h0);

    // Randomized traffic against the reference model.
    for (int it = 0; it < 400; it++) begin
      logic [15:0] cl;
      int r;
      cl = '0;
      for (int v = 0; v < 8; v++) begin
        r = int'($urandom_range(0, 5));
        cl[2*v +: 2] = (r == 0) ? 2'b01 : (r == 1) ? 2'b10 : (r == 2 && $urandom_range(0, 3) == 0) ? 2'b11 : 2'b00;
      end
      for (int v = 0; v < 8; v++) begin
        var_value_i[3*v +: 3] = {2'($urandom_range(0, 2)), 1'($urandom_range(0, 1))};
        var_lvl_i[16*v +: 16] = 16'($urandom_range(0, 40));
      end
      apply_impl_i = ($urandom_range(0, 3) != 0);
      apply_bkt_i  = ($urandom_range(0, 5) == 0);
      rst = ($urandom_range(0, 39) == 0);
      wr_i = ($urandom_range(0, 2) == 0) ? 8'($urandom) : (8'h01 << $urandom_range(0, 7));
      if ($urandom_range(0, 1) == 0) wr_i = '0;
      clause_i = cl;
      clause_len_i = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      #1;
      chk_model($sformatf("rnd%0d", it));
      @(posedge clk); #1;
      if (rst) model_reset();
      else model_write(wr_i, clause_i, clause_len_i);
      rst = 1'b0; wr_i = '0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
